// File: rtl/ocm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ocm_arbiter: two-core grant arbiter with atomic hold and timeout for OCM   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ocm_arbiter #(
  parameter int ADDR_BITS = 12,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [1:0]           i_req,
  input  logic [1:0]           i_done,
  input  logic [ADDR_BITS-1:0] i_addr0,
  input  logic [ADDR_BITS-1:0] i_addr1,
  input  logic [31:0]          i_wdata0,
  input  logic [31:0]          i_wdata1,
  input  logic [3:0]           i_we0,
  input  logic [3:0]           i_we1,
  input  logic [31:0]          i_mem_rdata,
  output logic [1:0]           o_grant,
  output logic [31:0]          o_rdata,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [31:0]          o_mem_wdata,
  output logic [3:0]           o_mem_we,
  output logic                 o_mem_en,
  output logic                 o_timeout
);

  localparam int                  c_cnt_w    = $clog2(TIMEOUT);
  localparam logic [c_cnt_w-1:0]  c_hold_max = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_prio;
  logic [c_cnt_w-1:0] r_hold;
  logic [1:0]         r_grant;
  logic               r_timeout;

  logic w_owner;
  logic w_voluntary;
  logic w_tmo;
  logic w_release;
  logic w_other_req;
  logic w_pick;

  always_comb begin
    w_owner     = (r_state == ST_OWN1);
    w_voluntary = i_done[w_owner] | ~i_req[w_owner];
    w_tmo       = (r_hold == c_hold_max);
    w_release   = (r_state != ST_IDLE) & (w_voluntary | w_tmo);
    w_other_req = i_req[~w_owner];
    // Contention from idle goes to the priority pointer; otherwise the lone requester.
    w_pick      = (i_req == 2'b11) ? r_prio : i_req[1];
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_grant   <= 2'b00;
      r_prio    <= 1'b0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (i_req != 2'b00) begin
          r_state <= w_pick ? ST_OWN1 : ST_OWN0;
          r_grant <= w_pick ? 2'b10 : 2'b01;
          r_hold  <= '0;
        end
      end else if (w_release) begin
        r_prio    <= ~w_owner;
        r_timeout <= w_tmo & ~w_voluntary;
        r_hold    <= '0;
        // Direct handover avoids an idle bubble; the releasing port always sits out a cycle.
        if (w_other_req) begin
          r_state <= w_owner ? ST_OWN0 : ST_OWN1;
          r_grant <= w_owner ? 2'b01 : 2'b10;
        end else begin
          r_state <= ST_IDLE;
          r_grant <= 2'b00;
        end
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 4'b0000;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (r_state)
      ST_OWN0: begin
        o_mem_en    = 1'b1;
        o_mem_we    = i_we0;
        o_mem_addr  = i_addr0;
        o_mem_wdata = i_wdata0;
      end
      ST_OWN1: begin
        o_mem_en    = 1'b1;
        o_mem_we    = i_we1;
        o_mem_addr  = i_addr1;
        o_mem_wdata = i_wdata1;
      end
      default: ;
    endcase
  end

  assign o_grant   = r_grant;
  assign o_timeout = r_timeout;
  assign o_rdata   = i_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ocm_arbiter.sv
`default_nettype none
// Testbench for ocm_arbiter: vector table, hand-written corner sequences and a
// randomized run against a behavioural ownership model.
module tb_ocm_arbiter;

  localparam int ADDR_BITS = 12;
  localparam int TIMEOUT   = 16;

  logic                 clk = 1'b0;
  logic                 nrst;
  logic [1:0]           i_req, i_done;
  logic [ADDR_BITS-1:0] i_addr0, i_addr1;
  logic [31:0]          i_wdata0, i_wdata1, i_mem_rdata;
  logic [3:0]           i_we0, i_we1;
  logic [1:0]           o_grant;
  logic [31:0]          o_rdata, o_mem_wdata;
  logic [ADDR_BITS-1:0] o_mem_addr;
  logic [3:0]           o_mem_we;
  logic                 o_mem_en, o_timeout;

  int n_pass  = 0;
  int n_total = 0;

  ocm_arbiter #(.ADDR_BITS(ADDR_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst), .i_req(i_req), .i_done(i_done),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .i_we0(i_we0), .i_we1(i_we1), .i_mem_rdata(i_mem_rdata),
    .o_grant(o_grant), .o_rdata(o_rdata), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_mem_en(o_mem_en),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: owner -1 means nobody holds the memory.
  int m_owner, m_hold, m_prio;
  bit m_tmo;

  task automatic model_edge();
    int k, o;
    bit vol, forced;
    if (!nrst) begin
      m_owner = -1; m_hold = 0; m_prio = 0; m_tmo = 0;
    end else if (m_owner < 0) begin
      m_tmo = 0;
      if (i_req == 2'b11) begin m_owner = m_prio; m_hold = 0; end
      else if (i_req == 2'b01) begin m_owner = 0; m_hold = 0; end
      else if (i_req == 2'b10) begin m_owner = 1; m_hold = 0; end
    end else begin
      k = m_owner;
      o = 1 - k;
      vol    = i_done[k] || !i_req[k];
      forced = (m_hold >= TIMEOUT - 1);
      if (vol || forced) begin
        m_prio  = o;
        m_tmo   = forced && !vol;
        m_owner = i_req[o] ? o : -1;
        m_hold  = 0;
      end else begin
        m_hold++;
        m_tmo = 0;
      end
    end
  endtask

  task automatic model_check(input string tag);
    logic [1:0]           eg;
    logic [3:0]           ewe;
    logic [ADDR_BITS-1:0] ea;
    logic [31:0]          ed;
    eg  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    ewe = (m_owner == 0) ? i_we0 : (m_owner == 1) ? i_we1 : 4'b0000;
    ea  = (m_owner == 0) ? i_addr0 : (m_owner == 1) ? i_addr1 : '0;
    ed  = (m_owner == 0) ? i_wdata0 : (m_owner == 1) ? i_wdata1 : 32'h0;
    chk({tag, " grant"},   32'(o_grant), 32'(eg));
    chk({tag, " en"},      32'(o_mem_en), 32'(m_owner >= 0));
    chk({tag, " we"},      32'(o_mem_we), 32'(ewe));
    chk({tag, " addr"},    32'(o_mem_addr), 32'(ea));
    chk({tag, " wdata"},   o_mem_wdata, ed);
    chk({tag, " rdata"},   o_rdata, i_mem_rdata);
    chk({tag, " timeout"}, 32'(o_timeout), 32'(m_tmo));
  endtask

  typedef struct {
    logic       nrst;
    logic [1:0] req;
    logic [1:0] done;
    logic [3:0] we0;
    logic [3:0] we1;
    logic [1:0] g;
    logic       en;
    logic [3:0] we;
  } vec_t;

  vec_t tbl[16];

  task automatic do_reset();
    nrst = 1'b0; i_req = 2'b00; i_done = 2'b00; i_we0 = 4'h0; i_we1 = 4'h0;
    step();
    nrst = 1'b1;
  endtask

  initial begin
    logic [ADDR_BITS-1:0] ea;
    int cycles;

    nrst = 1'b0; i_req = 2'b00; i_done = 2'b00;
    i_addr0 = 12'h010; i_addr1 = 12'h020;
    i_wdata0 = 32'hDEADBEEF; i_wdata1 = 32'hCAFEF00D;
    i_we0 = 4'h0; i_we1 = 4'h0; i_mem_rdata = 32'h12345678;

    //         nrst  req    done   we0   we1   grant  en  we
    tbl[0]  = '{1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0};
    tbl[1]  = '{1'b1, 2'b01, 2'b00, 4'h0, 4'h0, 2'b01, 1'b1, 4'h0};
    tbl[2]  = '{1'b1, 2'b01, 2'b00, 4'hF, 4'h0, 2'b01, 1'b1, 4'hF};
    tbl[3]  = '{1'b1, 2'b00, 2'b00, 4'hF, 4'h0, 2'b00, 1'b0, 4'h0};
    tbl[4]  = '{1'b0, 2'b11, 2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0};
    tbl[5]  = '{1'b1, 2'b11, 2'b00, 4'h0, 4'h0, 2'b01, 1'b1, 4'h0};
    tbl[6]  = '{1'b1, 2'b11, 2'b01, 4'h0, 4'hF, 2'b10, 1'b1, 4'hF};
    tbl[7]  = '{1'b1, 2'b11, 2'b10, 4'h0, 4'h0, 2'b01, 1'b1, 4'h0};
    tbl[8]  = '{1'b1, 2'b11, 2'b00, 4'h0, 4'hF, 2'b01, 1'b1, 4'h0};
    tbl[9]  = '{1'b1, 2'b11, 2'b01, 4'h0, 4'h0, 2'b10, 1'b1, 4'h0};
    tbl[10] = '{1'b1, 2'b10, 2'b10, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0};
    tbl[11] = '{1'b1, 2'b10, 2'b00, 4'h0, 4'h0, 2'b10, 1'b1, 4'h0};
    tbl[12] = '{1'b1, 2'b10, 2'b00, 4'h0, 4'hF, 2'b10, 1'b1, 4'hF};
    tbl[13] = '{1'b0, 2'b10, 2'b00, 4'h0, 4'hF, 2'b00, 1'b0, 4'h0};
    tbl[14] = '{1'b1, 2'b11, 2'b00, 4'h0, 4'h0, 2'b01, 1'b1, 4'h0};
    tbl[15] = '{1'b1, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0};

    for (int i = 0; i < 16; i++) begin
      nrst = tbl[i].nrst; i_req = tbl[i].req; i_done = tbl[i].done;
      i_we0 = tbl[i].we0; i_we1 = tbl[i].we1;
      step();
      ea = (tbl[i].g == 2'b01) ? i_addr0 : (tbl[i].g == 2'b10) ? i_addr1 : '0;
      chk($sformatf("vec%0d grant", i), 32'(o_grant), 32'(tbl[i].g));
      chk($sformatf("vec%0d en", i), 32'(o_mem_en), 32'(tbl[i].en));
      chk($sformatf("vec%0d we", i), 32'(o_mem_we), 32'(tbl[i].we));
      chk($sformatf("vec%0d addr", i), 32'(o_mem_addr), 32'(ea));
      chk($sformatf("vec%0d timeout", i), 32'(o_timeout), 32'h0);
    end

    // Atomic op on port 0 while port 1 waits: only port 0 writes, handover on done.
    do_reset();
    i_req = 2'b11;
    step();
    chk("atomic grant0", 32'(o_grant), 32'h1);
    i_we0 = 4'hF; i_we1 = 4'hF;
    step();
    chk("atomic we", 32'(o_mem_we), 32'hF);
    chk("atomic addr", 32'(o_mem_addr), 32'h010);
    chk("atomic wdata", o_mem_wdata, 32'hDEADBEEF);
    i_we0 = 4'h0;
    step();
    chk("atomic hold", 32'(o_grant), 32'h1);
    chk("atomic we blocked", 32'(o_mem_we), 32'h0);
    i_done = 2'b01;
    step();
    i_done = 2'b00; i_we1 = 4'h0;
    chk("atomic handover", 32'(o_grant), 32'h2);
    chk("atomic addr1", 32'(o_mem_addr), 32'h020);

    // Timeout: port 0 holds without done while port 1 waits.
    do_reset();
    i_req = 2'b11;
    cycles = 0;
    step();
    while (o_grant == 2'b01 && cycles < 40) begin
      cycles++;
      step();
    end
    chk("timeout hold cycles", 32'(cycles), 32'(TIMEOUT));
    chk("timeout grant1", 32'(o_grant), 32'h2);
    chk("timeout pulse", 32'(o_timeout), 32'h1);
    i_req = 2'b10;
    step();
    chk("timeout pulse end", 32'(o_timeout), 32'h0);
    chk("timeout grant1 kept", 32'(o_grant), 32'h2);

    // Randomized run against the model; second phase keeps requests mostly held.
    nrst = 1'b0; i_req = 2'b00; i_done = 2'b00;
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 1200; c++) begin
        @(posedge clk);
        model_edge();
        #1;
        model_check($sformatf("rnd%0d.%0d", ph, c));
        if (o_grant == 2'b11) chk("grant onehot", 32'(o_grant), 32'h0);
        nrst = ($urandom_range(0, 99) != 0);
        if (ph == 0) i_req = 2'($urandom_range(0, 3));
        else i_req = {($urandom_range(0, 15) != 0), ($urandom_range(0, 15) != 0)};
        i_done = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        i_we0 = 4'($urandom); i_we1 = 4'($urandom);
        i_addr0 = 12'($urandom); i_addr1 = 12'($urandom);
        i_wdata0 = $urandom; i_wdata1 = $urandom; i_mem_rdata = $urandom;
        #1;
        model_check($sformatf("rndmux%0d.%0d", ph, c));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
